izh_param_loader: RTL and testbench

Serial parameter loader directly upstream of the Izhikevich neuron core.
- Deserialises the `load_mode` / `serial_data` pin stream into the four 8-bit model parameters a, b, c and d.
- Holds them stable for the neuron datapath.
- Reports load status through `params_ready` and the 3-bit `debug_state`.
- Parameters are updated atomically at frame commit; the neuron never sees a partially loaded set.

---
 rtl/izh_pkg.sv | 40 ++++
 rtl/izh_shift_in.sv | 44 ++++
 rtl/izh_param_loader.sv | 162 ++++++++++++++++
 tb/tb_izh_param_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared types, constants and checksum helper for the Izhikevich parameter loader.
// Frame length is selected by the IZH_PARAM_CHECKSUM_EN macro.
package izh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_ERROR    = 3'd4
    } izh_state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } izh_params_t;

    localparam logic [7:0] IZH_DEF_A = 8'h05;
    localparam logic [7:0] IZH_DEF_B = 8'h33;
    localparam logic [7:0] IZH_DEF_C = 8'hBF;
    localparam logic [7:0] IZH_DEF_D = 8'h08;

    localparam int FRAME_BITS_PLAIN = 32;
    localparam int FRAME_BITS_CSUM  = 40;

`ifdef IZH_PARAM_CHECKSUM_EN
    localparam int FRAME_BITS = FRAME_BITS_CSUM;
`else
    localparam int FRAME_BITS = FRAME_BITS_PLAIN;
`endif

    localparam int CNT_W = 6;

    function automatic logic [7:0] izh_checksum(input izh_params_t p);
        return p.a ^ p.b ^ p.c ^ p.d;
    endfunction

endpackage

// File: rtl/izh_shift_in.sv
// MSB-first serial shift register with a saturating bit counter and full flag.
// i_start loads a fresh frame with its first bit; i_shift appends further bits.
module izh_shift_in #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full = (r_count == CNT_W'(WIDTH));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_start) begin
            r_data  <= WIDTH'(i_bit);
            r_count <= CNT_W'(1);
        end else if (i_shift && !w_full) begin
            r_data <= {r_data[WIDTH-2:0], i_bit};
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/izh_param_loader.sv
// Serial loader for the Izhikevich a/b/c/d parameters with atomic commit.
// Define IZH_PARAM_CHECKSUM_EN to require a trailing a^b^c^d checksum byte.
module izh_param_loader
    import izh_pkg::*;
#(
    parameter logic [7:0] DEF_A = IZH_DEF_A,
    parameter logic [7:0] DEF_B = IZH_DEF_B,
    parameter logic [7:0] DEF_C = IZH_DEF_C,
    parameter logic [7:0] DEF_D = IZH_DEF_D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load_mode,
    input  logic       serial_data,
    output logic [7:0] param_a,
    output logic [7:0] param_b,
    output logic [7:0] param_c,
    output logic [7:0] param_d,
    output logic       params_ready,
    output logic       load_done,
    output logic       frame_error,
    output logic [2:0] debug_state
);

    izh_state_t            r_state;
    izh_state_t            w_state_nxt;
    izh_params_t           r_params;
    logic                  r_params_ready;
    logic                  r_load_done;
    logic                  r_frame_error;

    logic [FRAME_BITS-1:0] w_shadow;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_frame_end;
    logic                  w_csum_ok;
    izh_params_t           w_shadow_params;

    logic                  w_start;
    logic                  w_shift;
    logic                  w_commit;
    logic                  w_error;

    izh_shift_in #(
        .WIDTH (FRAME_BITS),
        .CNT_W (CNT_W)
    ) u_shift_in (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_shift (w_shift),
        .i_bit   (serial_data),
        .o_data  (w_shadow),
        .o_count (w_count),
        .o_full  (w_full)
    );

    // The bit being sampled now completes the frame.
    assign w_frame_end = w_full || (w_count == CNT_W'(FRAME_BITS - 1));

`ifdef IZH_PARAM_CHECKSUM_EN
    logic [FRAME_BITS-1:0] w_frame_nxt;
    izh_params_t           w_params_nxt;

    // Checksum is judged on the frame as it will stand after this bit.
    assign w_frame_nxt     = {w_shadow[FRAME_BITS-2:0], serial_data};
    assign w_params_nxt    = izh_params_t'(w_frame_nxt[FRAME_BITS-1:8]);
    assign w_csum_ok       = (izh_checksum(w_params_nxt) == w_frame_nxt[7:0]);
    assign w_shadow_params = izh_params_t'(w_shadow[FRAME_BITS-1:8]);
`else
    assign w_csum_ok       = 1'b1;
    assign w_shadow_params = izh_params_t'(w_shadow);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (enable) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (load_mode) begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!load_mode) begin
                        w_state_nxt = ST_ERROR;
                    end else if (w_frame_end) begin
                        w_state_nxt = w_csum_ok ? ST_COMMIT : ST_ERROR;
                    end
                end
                ST_COMMIT, ST_ERROR: begin
                    w_state_nxt = ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!load_mode) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_start  = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        w_error  = 1'b0;
        if (enable) begin
            unique case (r_state)
                ST_IDLE:     w_start  = load_mode;
                ST_SHIFT:    w_shift  = load_mode;
                ST_COMMIT:   w_commit = 1'b1;
                ST_ERROR:    w_error  = 1'b1;
                default: ;
            endcase
        end
    end

    // Pulses clear on a stalled cycle; the COMMIT/ERROR state simply waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_params       <= '{a: DEF_A, b: DEF_B, c: DEF_C, d: DEF_D};
            r_params_ready <= 1'b1;
            r_load_done    <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_load_done   <= w_commit;
            r_frame_error <= w_error;
            if (w_commit) begin
                r_params <= w_shadow_params;
            end
            if (w_commit || w_error) begin
                r_params_ready <= 1'b1;
            end else if (w_start) begin
                r_params_ready <= 1'b0;
            end
        end
    end

    assign param_a      = r_params.a;
    assign param_b      = r_params.b;
    assign param_c      = r_params.c;
    assign param_d      = r_params.d;
    assign params_ready = r_params_ready;
    assign load_done    = r_load_done;
    assign frame_error  = r_frame_error;
    assign debug_state  = r_state;

endmodule

// File: tb/tb_izh_param_loader.sv
// Randomised and directed bench for izh_param_loader with a frame-level reference model.
// Honours IZH_PARAM_CHECKSUM_EN for frame length and checksum byte.
module tb_izh_param_loader;

`ifdef IZH_PARAM_CHECKSUM_EN
    localparam int FB = 40;
`else
    localparam int FB = 32;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       load_mode = 1'b0;
    logic       serial_data = 1'b0;
    logic [7:0] param_a, param_b, param_c, param_d;
    logic       params_ready, load_done, frame_error;
    logic [2:0] debug_state;

    izh_param_loader dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load_mode    (load_mode),
        .serial_data  (serial_data),
        .param_a      (param_a),
        .param_b      (param_b),
        .param_c      (param_c),
        .param_d      (param_d),
        .params_ready (params_ready),
        .load_done    (load_done),
        .frame_error  (frame_error),
        .debug_state  (debug_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits collected so far, plus what the loader owes next.
    bit         q[$];
    bit         m_valid = 0;
    bit         m_collect = 0;
    bit         m_drain = 0;
    int         m_pend = 0;   // 0 none, 1 commit owed, 2 error owed
    logic [7:0] m_a, m_b, m_c, m_d;
    logic       m_ready, m_done, m_err;

    function automatic logic [7:0] frame_byte(input int k);
        logic [7:0] v = 8'h00;
        for (int j = 0; j < 8; j++) v = {v[6:0], q[8*k+j]};
        return v;
    endfunction

    function automatic bit frame_ok();
        if (FB == 40)
            return frame_byte(4) == (frame_byte(0) ^ frame_byte(1) ^ frame_byte(2) ^ frame_byte(3));
        return 1'b1;
    endfunction

    function automatic logic [2:0] m_state();
        if (m_collect)   return 3'd1;
        if (m_pend == 1) return 3'd2;
        if (m_pend == 2) return 3'd4;
        if (m_drain)     return 3'd3;
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_a = 8'h05; m_b = 8'h33; m_c = 8'hBF; m_d = 8'h08;
            m_ready = 1; m_done = 0; m_err = 0;
            m_collect = 0; m_drain = 0; m_pend = 0;
            q.delete();
        end else if (!enable) begin
            m_done = 0; m_err = 0;
        end else begin
            m_done = 0; m_err = 0;
            if (m_pend == 1) begin
                m_a = frame_byte(0); m_b = frame_byte(1);
                m_c = frame_byte(2); m_d = frame_byte(3);
                m_done = 1; m_ready = 1; m_pend = 0; m_drain = 1;
            end else if (m_pend == 2) begin
                m_err = 1; m_ready = 1; m_pend = 0; m_drain = 1;
            end else if (m_collect) begin
                if (!load_mode) begin
                    m_collect = 0; m_pend = 2;
                end else begin
                    q.push_back(serial_data);
                    if (q.size() == FB) begin
                        m_collect = 0;
                        m_pend = frame_ok() ? 1 : 2;
                    end
                end
            end else if (m_drain) begin
                if (!load_mode) m_drain = 0;
            end else if (load_mode) begin
                q.delete();
                q.push_back(serial_data);
                m_collect = 1;
                m_ready = 0;
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("param_a", 32'(param_a), 32'(m_a));
            check("param_b", 32'(param_b), 32'(m_b));
            check("param_c", 32'(param_c), 32'(m_c));
            check("param_d", 32'(param_d), 32'(m_d));
            check("params_ready", 32'(params_ready), 32'(m_ready));
            check("load_done", 32'(load_done), 32'(m_done));
            check("frame_error", 32'(frame_error), 32'(m_err));
            check("debug_state", 32'(debug_state), 32'(m_state()));
            if (load_done)   n_done++;
            if (frame_error) n_err++;
        end
    end

    task automatic drive(input logic rs, input logic en, input logic lm, input logic sd);
        @(posedge clk);
        #1;
        reset = rs; enable = en; load_mode = lm; serial_data = sd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'($urandom % 2));
    endtask

    // Sends nbits with load_mode high; bits beyond the frame are random filler.
    task automatic send_bits(input logic [39:0] frame, input int nbits, input int stall_at,
                             input bit rand_en);
        int i = 0;
        while (i < nbits) begin
            logic b;
            logic en;
            if (i == stall_at)
                for (int s = 0; s < 5; s++) drive(1'b0, 1'b0, 1'b1, 1'($urandom % 2));
            b  = (i < FB) ? frame[FB-1-i] : 1'($urandom % 2);
            en = rand_en ? ($urandom % 8 != 0) : 1'b1;
            drive(1'b0, en, 1'b1, b);
            if (en) i++;
        end
    endtask

    function automatic logic [39:0] mk_frame(input logic [7:0] a, b, c, d, chk);
        if (FB == 40) return {a, b, c, d, chk};
        return {8'h00, a, b, c, d};
    endfunction

    int d0, e0;

    initial begin
        // Reset held two cycles.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_a", 32'(param_a), 32'h05);
        check("rst_b", 32'(param_b), 32'h33);
        check("rst_c", 32'(param_c), 32'hBF);
        check("rst_d", 32'(param_d), 32'h08);
        check("rst_ready", 32'(params_ready), 32'd1);
        check("rst_state", 32'(debug_state), 32'd0);

        // Good frame; checksum 02^33^C1^02 = F2.
        d0 = n_done; e0 = n_err;
        send_bits(mk_frame(8'h02, 8'h33, 8'hC1, 8'h02, 8'hF2), FB, -1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("good_state_commit", 32'(debug_state), 32'd2);
        check("good_ready_low", 32'(params_ready), 32'd0);
        idle(1);
        @(negedge clk);
        check("good_done_pulse", 32'(load_done), 32'd1);
        idle(3);
        @(negedge clk);
        check("good_a", 32'(param_a), 32'h02);
        check("good_c", 32'(param_c), 32'hC1);
        check("good_done_cnt", 32'(n_done - d0), 32'd1);
        check("good_err_cnt", 32'(n_err - e0), 32'd0);

        // Short frame: 20 bits then load_mode low.
        d0 = n_done; e0 = n_err;
        send_bits(mk_frame(8'hAA, 8'h55, 8'h11, 8'h22, 8'h00), 20, -1, 0);
        idle(5);
        @(negedge clk);
        check("short_err_cnt", 32'(n_err - e0), 32'd1);
        check("short_done_cnt", 32'(n_done - d0), 32'd0);
        check("short_b_kept", 32'(param_b), 32'h33);
        check("short_ready", 32'(params_ready), 32'd1);

`ifdef IZH_PARAM_CHECKSUM_EN
        d0 = n_done; e0 = n_err;
        send_bits(mk_frame(8'h02, 8'h33, 8'hC1, 8'h02, 8'h00), FB, -1, 0);
        idle(5);
        @(negedge clk);
        check("badcs_err_cnt", 32'(n_err - e0), 32'd1);
        check("badcs_done_cnt", 32'(n_done - d0), 32'd0);
`endif

        // Stall mid-frame after a reset back to defaults.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        d0 = n_done; e0 = n_err;
        send_bits(mk_frame(8'h02, 8'h33, 8'hC1, 8'h02, 8'hF2), FB, 13, 0);
        idle(4);
        @(negedge clk);
        check("stall_a", 32'(param_a), 32'h02);
        check("stall_d", 32'(param_d), 32'h02);
        check("stall_done_cnt", 32'(n_done - d0), 32'd1);
        check("stall_err_cnt", 32'(n_err - e0), 32'd0);

        // Reset after 16 bits discards the partial frame silently.
        d0 = n_done; e0 = n_err;
        send_bits(mk_frame(8'h77, 8'h66, 8'h55, 8'h44, 8'h00), 16, -1, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);
        @(negedge clk);
        check("rstmid_a", 32'(param_a), 32'h05);
        check("rstmid_c", 32'(param_c), 32'hBF);
        check("rstmid_pulses", 32'(n_done - d0 + n_err - e0), 32'd0);

        // Frame followed by 8 extra bits: one commit, parked in WAIT_LOW.
        d0 = n_done; e0 = n_err;
        send_bits(mk_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h40), FB + 8, -1, 0);
        @(negedge clk);
        check("extra_state", 32'(debug_state), 32'd3);
        check("extra_done_cnt", 32'(n_done - d0), 32'd1);
        check("extra_b", 32'(param_b), 32'h20);
        idle(2);
        @(negedge clk);
        check("extra_idle", 32'(debug_state), 32'd0);

        // Randomised frames against the model.
        for (int f = 0; f < 80; f++) begin
            int kind;
            int len;
            logic [7:0] a, b, c, d, chk;
            for (int g = 0; g < 1 + int'($urandom % 4); g++)
                drive(1'b0, 1'($urandom % 4 != 0), 1'b0, 1'($urandom % 2));
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            chk = a ^ b ^ c ^ d;
            kind = int'($urandom % 5);
            case (kind)
                1:       len = 1 + int'($urandom % (FB - 1));
                2:       len = FB + 1 + int'($urandom % 8);
                3: begin len = FB; chk = chk ^ (8'd1 << ($urandom % 8)); end
                default: len = FB;
            endcase
            if ($urandom % 20 == 0) begin
                send_bits(mk_frame(a, b, c, d, chk), 1 + int'($urandom % (FB - 1)), -1, 1);
                drive(1'b1, 1'b1, 1'b0, 1'b0);
            end else begin
                send_bits(mk_frame(a, b, c, d, chk), len, -1, 1);
            end
            drive(1'b0, 1'($urandom % 2), 1'b0, 1'b0);
        end
        idle(6);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
